// File: rtl/cmp_pkg.sv
// Shared types and compare helper for the hysteresis comparator.
// Channel FSM states are exported so debug ports can carry them.
package cmp_pkg;

  typedef enum logic [1:0] {
    LOW     = 2'd0,
    PEND_HI = 2'd1,
    HIGH    = 2'd2,
    PEND_LO = 2'd3
  } hyst_state_t;

  localparam int MAX_W = 64;

  // Operands arrive zero-extended from a 'width'-bit field. Flipping the field's
  // sign bit maps two's-complement order onto plain unsigned order.
  function automatic logic gt_s(input logic [MAX_W-1:0] a,
                                input logic [MAX_W-1:0] b,
                                input logic             signed_mode,
                                input int               width);
    logic [MAX_W-1:0] flip;
    flip = signed_mode ? (MAX_W'(1) << (width - 1)) : '0;
    return (a ^ flip) > (b ^ flip);
  endfunction

endpackage

// File: rtl/cmp_hyst_channel.sv
// One comparator channel: hysteresis FSM with debounce counter, rise pulse
// and sticky alarm. State is exported on o_state for observation.
module cmp_hyst_channel
  import cmp_pkg::*;
#(
  parameter int WIDTH    = 10,
  parameter int DEBOUNCE = 3,
  parameter int SIGNED   = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_sample,
  input  logic [WIDTH-1:0] i_thr_hi,
  input  logic [WIDTH-1:0] i_thr_lo,
  input  logic             i_clear,
  output logic             o_above,
  output logic             o_rise,
  output logic             o_sticky,
  output hyst_state_t      o_state
);

  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [CW:0] DEB_V = (CW + 1)'(DEBOUNCE);

  hyst_state_t   r_state;
  logic [CW-1:0] r_cnt;
  logic          r_rise;
  logic          r_sticky;

  hyst_state_t   w_state_next;
  logic [CW-1:0] w_cnt_next;
  logic          w_rise_next;
  logic          w_up_q;
  logic          w_dn_q;
  logic [CW:0]   w_cnt_inc;
  logic          w_run_done;

  assign w_up_q     = gt_s(MAX_W'(i_sample), MAX_W'(i_thr_hi), SIGNED != 0, WIDTH);
  assign w_dn_q     = gt_s(MAX_W'(i_thr_lo), MAX_W'(i_sample), SIGNED != 0, WIDTH);
  assign w_cnt_inc  = {1'b0, r_cnt} + (CW + 1)'(1);
  assign w_run_done = (w_cnt_inc == DEB_V);

  // Invalid cycles leave state and count untouched, so a run survives gaps.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_rise_next  = 1'b0;
    if (i_valid) begin
      case (r_state)
        LOW: begin
          if (w_up_q) begin
            if (DEBOUNCE == 1) begin
              w_state_next = HIGH;
              w_cnt_next   = '0;
              w_rise_next  = 1'b1;
            end else begin
              w_state_next = PEND_HI;
              w_cnt_next   = CW'(1);
            end
          end
        end
        PEND_HI: begin
          if (w_up_q) begin
            if (w_run_done) begin
              w_state_next = HIGH;
              w_cnt_next   = '0;
              w_rise_next  = 1'b1;
            end else begin
              w_cnt_next = w_cnt_inc[CW-1:0];
            end
          end else begin
            w_state_next = LOW;
            w_cnt_next   = '0;
          end
        end
        HIGH: begin
          if (w_dn_q) begin
            if (DEBOUNCE == 1) begin
              w_state_next = LOW;
              w_cnt_next   = '0;
            end else begin
              w_state_next = PEND_LO;
              w_cnt_next   = CW'(1);
            end
          end
        end
        PEND_LO: begin
          if (w_dn_q) begin
            if (w_run_done) begin
              w_state_next = LOW;
              w_cnt_next   = '0;
            end else begin
              w_cnt_next = w_cnt_inc[CW-1:0];
            end
          end else begin
            w_state_next = HIGH;
            w_cnt_next   = '0;
          end
        end
        default: begin
          w_state_next = LOW;
          w_cnt_next   = '0;
        end
      endcase
    end
  end

  // Sticky takes the rise in the same edge as the pulse, so set beats clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= LOW;
      r_cnt    <= '0;
      r_rise   <= 1'b0;
      r_sticky <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_cnt    <= w_cnt_next;
      r_rise   <= w_rise_next;
      r_sticky <= (r_sticky & ~i_clear) | w_rise_next;
    end
  end

  assign o_above  = (r_state == HIGH) || (r_state == PEND_LO);
  assign o_rise   = r_rise;
  assign o_sticky = r_sticky;
  assign o_state  = r_state;

endmodule

// File: rtl/cmp_hyst_monitor.sv
// Multi-channel hysteresis comparator: one debounced channel per sample slice
// of a_flat, shared thresholds and clear. state_dbg carries each channel's FSM state.
module cmp_hyst_monitor
  import cmp_pkg::*;
#(
  parameter int WIDTH    = 10,
  parameter int CHANNELS = 4,
  parameter int DEBOUNCE = 3,
  parameter int SIGNED   = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  input  logic [CHANNELS*WIDTH-1:0] a_flat,
  input  logic [WIDTH-1:0]          thr_hi,
  input  logic [WIDTH-1:0]          thr_lo,
  input  logic                      clear,
  output logic [CHANNELS-1:0]       above,
  output logic [CHANNELS-1:0]       rise,
  output logic [CHANNELS-1:0]       sticky,
  output logic                      out_valid,
  output logic [2*CHANNELS-1:0]     state_dbg
);

  logic        r_out_valid;
  hyst_state_t w_state [CHANNELS];

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    cmp_hyst_channel #(
      .WIDTH    (WIDTH),
      .DEBOUNCE (DEBOUNCE),
      .SIGNED   (SIGNED)
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .i_valid  (in_valid),
      .i_sample (a_flat[g*WIDTH +: WIDTH]),
      .i_thr_hi (thr_hi),
      .i_thr_lo (thr_lo),
      .i_clear  (clear),
      .o_above  (above[g]),
      .o_rise   (rise[g]),
      .o_sticky (sticky[g]),
      .o_state  (w_state[g])
    );
    assign state_dbg[2*g +: 2] = w_state[g];
  end

  always_ff @(posedge clk) begin
    if (reset) r_out_valid <= 1'b0;
    else       r_out_valid <= in_valid;
  end

  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_cmp_hyst_monitor.sv
// Bench for cmp_hyst_monitor: an unsigned and a signed instance share stimulus
// and are checked against a run-length model of the hysteresis rules.
module tb_cmp_hyst_monitor;
  localparam int W   = 10;
  localparam int N   = 4;
  localparam int DEB = 3;
  localparam int EW  = 6*N + 1;

  logic           clk = 1'b0;
  logic           reset, in_valid, clear;
  logic [N*W-1:0] a_flat;
  logic [W-1:0]   thr_hi, thr_lo;
  logic [N-1:0]   u_above, u_rise, u_sticky, s_above, s_rise, s_sticky;
  logic           u_ov, s_ov;
  logic [2*N-1:0] u_state_dbg, s_state_dbg;
  logic [EW-1:0]  obs;
  logic [EW-1:0]  exp_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  // Model: per instance (0 = unsigned, 1 = signed) and channel.
  int m_run    [2][N];
  bit m_above  [2][N];
  bit m_rise   [2][N];
  bit m_sticky [2][N];
  bit m_ov;

  always #5 clk = ~clk;

  cmp_hyst_monitor #(.WIDTH(W), .CHANNELS(N), .DEBOUNCE(DEB), .SIGNED(0)) dut_u (
    .clk(clk), .reset(reset), .in_valid(in_valid), .a_flat(a_flat),
    .thr_hi(thr_hi), .thr_lo(thr_lo), .clear(clear),
    .above(u_above), .rise(u_rise), .sticky(u_sticky),
    .out_valid(u_ov), .state_dbg(u_state_dbg)
  );

  cmp_hyst_monitor #(.WIDTH(W), .CHANNELS(N), .DEBOUNCE(DEB), .SIGNED(1)) dut_s (
    .clk(clk), .reset(reset), .in_valid(in_valid), .a_flat(a_flat),
    .thr_hi(thr_hi), .thr_lo(thr_lo), .clear(clear),
    .above(s_above), .rise(s_rise), .sticky(s_sticky),
    .out_valid(s_ov), .state_dbg(s_state_dbg)
  );

  assign obs = {u_ov & s_ov, s_sticky, s_rise, s_above, u_sticky, u_rise, u_above};

  function automatic int to_int(input logic [W-1:0] v, input bit sgn);
    int r;
    r = int'(v);
    if (sgn && v[W-1]) r = r - (1 << W);
    return r;
  endfunction

  function automatic logic [W-1:0] pick(input logic [W-1:0] hi, input logic [W-1:0] lo);
    case ($urandom_range(0, 2))
      0:       return W'(int'(hi) + int'($urandom_range(0, 2)) - 1);
      1:       return W'(int'(lo) + int'($urandom_range(0, 2)) - 1);
      default: return W'($urandom);
    endcase
  endfunction

  // Qualifying samples extend a run; a run of DEB flips the level.
  task automatic model_step();
    logic [EW-1:0] e;
    int x, hi, lo;
    bit q;
    e = '0;
    for (int k = 0; k < 2; k++) begin
      hi = to_int(thr_hi, k == 1);
      lo = to_int(thr_lo, k == 1);
      for (int c = 0; c < N; c++) begin
        x = to_int(a_flat[c*W +: W], k == 1);
        m_rise[k][c] = 1'b0;
        if (reset) begin
          m_run[k][c] = 0; m_above[k][c] = 1'b0; m_sticky[k][c] = 1'b0;
        end else begin
          if (in_valid) begin
            q = m_above[k][c] ? (x < lo) : (x > hi);
            if (q) begin
              m_run[k][c]++;
              if (m_run[k][c] == DEB) begin
                m_above[k][c] = !m_above[k][c];
                m_run[k][c]   = 0;
                m_rise[k][c]  = m_above[k][c];
              end
            end else begin
              m_run[k][c] = 0;
            end
          end
          m_sticky[k][c] = (m_sticky[k][c] && !clear) || m_rise[k][c];
        end
        e[3*N*k + c]       = m_above[k][c];
        e[3*N*k + N + c]   = m_rise[k][c];
        e[3*N*k + 2*N + c] = m_sticky[k][c];
      end
    end
    m_ov = reset ? 1'b0 : in_valid;
    e[6*N] = m_ov;
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic v, input logic clr);
    in_valid = v;
    clear    = clr;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic set_ch(input int c, input logic [W-1:0] v);
    a_flat[c*W +: W] = v;
  endtask

  task automatic set_all(input logic [W-1:0] v);
    for (int c = 0; c < N; c++) a_flat[c*W +: W] = v;
  endtask

  task automatic test_reset();
    logic [EW-1:0] e;
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      a_flat = {$urandom, $urandom};
      drive(1'($urandom), 1'($urandom));
      e = exp_q.pop_front();
      n_cmp++;
      if (obs !== e) begin n_bad++; $display("FAIL reset_model: obs=%h exp=%h", obs, e); end
      n_cmp++;
      if (obs !== '0) begin n_bad++; $display("FAIL reset_zero: obs=%h exp=0", obs); end
    end
    reset  = 1'b0;
    a_flat = {$urandom, $urandom};
    drive(1'($urandom), 1'b0);
    e = exp_q.pop_front();
    n_cmp++;
    if (obs !== e) begin n_bad++; $display("FAIL reset_after_model: obs=%h exp=%h", obs, e); end
    n_cmp++;
    if ({u_above, u_rise, u_sticky} !== '0) begin
      n_bad++; $display("FAIL reset_after_zero: obs=%h exp=0", {u_above, u_rise, u_sticky});
    end
  endtask

  task automatic test_rise();
    logic [W-1:0] seq [3] = '{10'd601, 10'd650, 10'd700};
    logic [EW-1:0] e;
    set_all(10'd500);
    drive(1'b1, 1'b0);
    e = exp_q.pop_front();
    n_cmp++;
    if (obs !== e) begin n_bad++; $display("FAIL rise_settle: obs=%h exp=%h", obs, e); end
    for (int i = 0; i < 3; i++) begin
      set_ch(0, seq[i]);
      drive(1'b1, 1'b0);
      e = exp_q.pop_front();
      n_cmp++;
      if (obs !== e) begin n_bad++; $display("FAIL rise_model[%0d]: obs=%h exp=%h", i, obs, e); end
    end
    n_cmp++;
    if ({u_above[0], u_rise[0]} !== 2'b11) begin
      n_bad++; $display("FAIL rise_ch0: above,rise=%b want 11", {u_above[0], u_rise[0]});
    end
    set_ch(0, 10'd500);
    drive(1'b0, 1'b0);
    e = exp_q.pop_front();
    n_cmp++;
    if (obs !== e) begin n_bad++; $display("FAIL rise_next_model: obs=%h exp=%h", obs, e); end
    n_cmp++;
    if ({u_above[0], u_rise[0], u_sticky[0]} !== 3'b101) begin
      n_bad++; $display("FAIL rise_one_cycle: above,rise,sticky=%b want 101",
                        {u_above[0], u_rise[0], u_sticky[0]});
    end
  endtask

  task automatic test_run_break();
    logic [W-1:0] seq [8] = '{10'd700, 10'd700, 10'd500, 10'd700, 10'd700,
                              10'd600, 10'd600, 10'd600};
    logic [EW-1:0] e;
    for (int i = 0; i < 8; i++) begin
      set_ch(1, seq[i]);
      drive(1'b1, 1'b0);
      e = exp_q.pop_front();
      n_cmp++;
      if (obs !== e) begin n_bad++; $display("FAIL break_model[%0d]: obs=%h exp=%h", i, obs, e); end
      n_cmp++;
      if ({u_above[1], u_rise[1]} !== 2'b00) begin
        n_bad++; $display("FAIL break_ch1[%0d]: above,rise=%b want 00", i, {u_above[1], u_rise[1]});
      end
    end
    set_ch(1, 10'd500);
  endtask

  task automatic test_gap_and_fall();
    logic [W-1:0] smp [15] = '{10'd700, 10'd0, 10'd0, 10'd0, 10'd0, 10'd700, 10'd700,
                               10'd450, 10'd450, 10'd450, 10'd450, 10'd450,
                               10'd399, 10'd399, 10'd399};
    bit vld [15] = '{1, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
    bit want_above [15] = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 0};
    logic [EW-1:0] e;
    for (int i = 0; i < 15; i++) begin
      set_ch(2, smp[i]);
      drive(vld[i], 1'b0);
      e = exp_q.pop_front();
      n_cmp++;
      if (obs !== e) begin n_bad++; $display("FAIL gap_model[%0d]: obs=%h exp=%h", i, obs, e); end
      n_cmp++;
      if (u_above[2] !== want_above[i]) begin
        n_bad++; $display("FAIL gap_above2[%0d]: got %b want %b", i, u_above[2], want_above[i]);
      end
    end
    set_ch(2, 10'd500);
  endtask

  task automatic test_clear();
    logic [EW-1:0] e;
    drive(1'b0, 1'b1);
    e = exp_q.pop_front();
    n_cmp++;
    if (obs !== e) begin n_bad++; $display("FAIL clear_model: obs=%h exp=%h", obs, e); end
    n_cmp++;
    if (u_sticky !== 4'b0000) begin n_bad++; $display("FAIL clear_sticky: got %b want 0000", u_sticky); end
    set_ch(3, 10'd700);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, i == 2);
      e = exp_q.pop_front();
      n_cmp++;
      if (obs !== e) begin n_bad++; $display("FAIL clear_rise_model[%0d]: obs=%h exp=%h", i, obs, e); end
    end
    n_cmp++;
    if ({u_rise[3], u_sticky[3]} !== 2'b11) begin
      n_bad++; $display("FAIL clear_vs_set: rise,sticky=%b want 11", {u_rise[3], u_sticky[3]});
    end
    set_ch(3, 10'd500);
  endtask

  task automatic test_signed();
    logic [EW-1:0] e;
    thr_hi = 10'd0;
    thr_lo = 10'h3F6;
    set_all(10'h3F8);
    set_ch(1, 10'h3F0);
    reset = 1'b1;
    drive(1'b0, 1'b0);
    void'(exp_q.pop_front());
    reset = 1'b0;
    set_ch(0, 10'd1);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0);
      e = exp_q.pop_front();
      n_cmp++;
      if (obs !== e) begin n_bad++; $display("FAIL signed_up_model[%0d]: obs=%h exp=%h", i, obs, e); end
    end
    n_cmp++;
    if ({s_above[0], s_rise[0], s_above[1], u_rise[1]} !== 4'b1101) begin
      n_bad++; $display("FAIL signed_up: s_above0,s_rise0,s_above1,u_rise1=%b want 1101",
                        {s_above[0], s_rise[0], s_above[1], u_rise[1]});
    end
    set_ch(0, 10'h3F0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0);
      e = exp_q.pop_front();
      n_cmp++;
      if (obs !== e) begin n_bad++; $display("FAIL signed_dn_model[%0d]: obs=%h exp=%h", i, obs, e); end
      n_cmp++;
      if (s_above[0] !== (i < 2)) begin
        n_bad++; $display("FAIL signed_fall[%0d]: s_above0=%b want %b", i, s_above[0], i < 2);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [EW-1:0] e;
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 24) == 0) begin
        thr_hi = W'($urandom);
        thr_lo = W'($urandom);
      end
      for (int c = 0; c < N; c++)
        if ($urandom_range(0, 3) != 0) set_ch(c, pick(thr_hi, thr_lo));
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
      e = exp_q.pop_front();
      n_cmp++;
      if (obs !== e) begin n_bad++; $display("FAIL random[%0d]: obs=%h exp=%h", i, obs, e); end
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; clear = 1'b0; a_flat = '0;
    thr_hi = 10'd600; thr_lo = 10'd400;
    test_reset();
    test_rise();
    test_run_break();
    test_gap_and_fall();
    test_clear();
    test_signed();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
